// File: rtl/dual_request_queue_pkg.sv
// rtl/dual_request_queue_pkg.sv - shared types, constants and grant check for dual_request_queue
//
// Purpose: source tag type, source constants and the grant-validity helper
//          used by the dual_request_queue top level.
// Contents:
//   src_t         - 1-bit source channel tag
//   SRC_0, SRC_1  - channel tag values
//   onehot_valid  - per-channel valid-grant vector from grants/requests
package dual_request_queue_pkg;

  typedef logic src_t;

  localparam src_t SRC_0 = 1'b0;
  localparam src_t SRC_1 = 1'b1;

  // Bit i is set only when the grant is exactly onehot(i) and channel i is
  // actually requesting; every other grant pattern yields 2'b00.
  function automatic logic [1:0] onehot_valid(input logic [1:0] grants,
                                              input logic [1:0] requests);
    logic [1:0] vg;
    vg[0] = (grants == 2'b01) & requests[0];
    vg[1] = (grants == 2'b10) & requests[1];
    return vg;
  endfunction

endpackage

// File: rtl/dual_request_queue_fifo.sv
// rtl/dual_request_queue_fifo.sv - per-channel request FIFO (module request_fifo)
//
// Purpose: synchronous FIFO with registered occupancy; no full or empty bypass.
// Parameters: WIDTH (word bits), DEPTH (entries, power of two, >= 2)
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   push, wdata   - write strobe and word (ignored when full)
//   pop, rdata    - read strobe (ignored when empty) and head word
//   empty, full   - decoded from the registered count only
module request_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [CW-1:0] COUNT_ONE  = CW'(1);
  localparam logic [PW-1:0] PTR_ONE    = PW'(1);

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok, pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_COUNT);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata   = mem_q[rd_ptr_q];

  // Pointers wrap naturally at DEPTH since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + COUNT_ONE;
      2'b01:   count_d = count_q - COUNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: a reset count makes old entries unreachable.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/dual_request_queue.sv
// rtl/dual_request_queue.sv - two-channel requester front end for a 2-input arbiter
//
// Purpose: two private FIFOs raise requests from occupancy; a valid one-hot
//          grant pops the granted FIFO into a registered tagged output.
// Optional feature: DUAL_REQUEST_QUEUE_ERR_CHECK_EN enables the sticky err flag;
//          when undefined err is tied to 0.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   up_valid[1:0]       - producer i offers a word
//   up_data0, up_data1  - channel words
//   up_ready[1:0]       - FIFO i not full
//   requests[1:0]       - FIFO i non-empty (registered state only)
//   grants[1:0]         - arbiter grant, expected one-hot
//   out_valid/out_data/out_src - registered delivered word and its channel
//   err                 - sticky protocol error
module dual_request_queue
  import dual_request_queue_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       up_valid,
  input  logic [WIDTH-1:0] up_data0,
  input  logic [WIDTH-1:0] up_data1,
  output logic [1:0]       up_ready,
  output logic [1:0]       requests,
  input  logic [1:0]       grants,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  output logic             err
);

  logic [1:0]       fifo_empty, fifo_full;
  logic [1:0]       push, valid_grant;
  logic [WIDTH-1:0] rdata0, rdata1;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  src_t             out_src_q, out_src_d;

  assign up_ready    = ~fifo_full;
  assign requests    = ~fifo_empty;
  assign push        = up_valid & up_ready;
  assign valid_grant = onehot_valid(grants, requests);

  request_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
    .clk   (clk),
    .rst   (rst),
    .push  (push[0]),
    .pop   (valid_grant[0]),
    .wdata (up_data0),
    .rdata (rdata0),
    .empty (fifo_empty[0]),
    .full  (fifo_full[0])
  );

  request_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
    .clk   (clk),
    .rst   (rst),
    .push  (push[1]),
    .pop   (valid_grant[1]),
    .wdata (up_data1),
    .rdata (rdata1),
    .empty (fifo_empty[1]),
    .full  (fifo_full[1])
  );

  // Data and source hold their last delivered values on idle cycles.
  always_comb begin
    out_valid_d = |valid_grant;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    if (valid_grant[1]) begin
      out_data_d = rdata1;
      out_src_d  = SRC_1;
    end else if (valid_grant[0]) begin
      out_data_d = rdata0;
      out_src_d  = SRC_0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= SRC_0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

`ifdef DUAL_REQUEST_QUEUE_ERR_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if ((grants == 2'b11) || ((grants & ~requests) != 2'b00)) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_dual_request_queue.sv
// tb/tb_dual_request_queue.sv - self-checking bench for dual_request_queue
module tb_dual_request_queue;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
`ifdef DUAL_REQUEST_QUEUE_ERR_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic [1:0]       up_valid;
  logic [WIDTH-1:0] up_data0, up_data1;
  logic [1:0]       up_ready, requests, grants;
  logic             out_valid, out_src, err;
  logic [WIDTH-1:0] out_data;

  dual_request_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .up_valid  (up_valid),
    .up_data0  (up_data0),
    .up_data1  (up_data1),
    .up_ready  (up_ready),
    .requests  (requests),
    .grants    (grants),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  // Reference model: per-channel queues plus a scoreboard of expected outputs.
  logic [7:0] mq0[$];
  logic [7:0] mq1[$];
  logic [8:0] sb[$];
  logic [7:0] last_d;
  logic       last_s;
  logic       err_exp;

  typedef struct {
    logic [1:0] uv;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [1:0] g;
    logic [1:0] exp_req;
    logic [1:0] exp_rdy;
    logic       exp_ov;
    logic [7:0] exp_od;
    logic       exp_os;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called just after a rising edge; drives one cycle and checks both sides of the next edge.
  task automatic step(input logic [1:0] uv, input logic [7:0] d0, input logic [7:0] d1,
                      input logic [1:0] g, output logic [1:0] req_seen,
                      output logic [1:0] rdy_seen);
    logic [1:0] mreq, mrdy, vg;
    logic [7:0] w;
    logic [8:0] e;
    up_valid = uv;
    up_data0 = d0;
    up_data1 = d1;
    grants   = g;
    @(negedge clk);
    mreq = {mq1.size() != 0, mq0.size() != 0};
    mrdy = {mq1.size() != DEPTH, mq0.size() != DEPTH};
    req_seen = requests;
    rdy_seen = up_ready;
    chk("requests", 32'(requests), 32'(mreq));
    chk("up_ready", 32'(up_ready), 32'(mrdy));
    vg = 2'b00;
    if (g == 2'b01 && mreq[0]) vg = 2'b01;
    else if (g == 2'b10 && mreq[1]) vg = 2'b10;
    if (ERR_EN && (g == 2'b11 || (g & ~mreq) != 2'b00)) err_exp = 1'b1;
    if (vg[0]) begin w = mq0.pop_front(); sb.push_back({1'b0, w}); end
    if (vg[1]) begin w = mq1.pop_front(); sb.push_back({1'b1, w}); end
    if (uv[0] && mrdy[0]) mq0.push_back(d0);
    if (uv[1] && mrdy[1]) mq1.push_back(d1);
    @(posedge clk);
    #1;
    if (vg != 2'b00) begin
      e = sb.pop_front();
      chk("out_valid", 32'(out_valid), 32'd1);
      chk("out_data", 32'(out_data), 32'(e[7:0]));
      chk("out_src", 32'(out_src), 32'(e[8]));
      last_d = e[7:0];
      last_s = e[8];
    end else begin
      chk("out_valid_idle", 32'(out_valid), 32'd0);
      chk("out_data_hold", 32'(out_data), 32'(last_d));
      chk("out_src_hold", 32'(out_src), 32'(last_s));
    end
    chk("err", 32'(err), 32'(err_exp));
  endtask

  logic [1:0] rs, ys;

  initial begin
    // uv, d0, d1, g | req, rdy before edge | ov, od, os after edge
    vecs[0]  = '{2'b01, 8'hA1, 8'h00, 2'b00, 2'b00, 2'b11, 1'b0, 8'h00, 1'b0};
    vecs[1]  = '{2'b00, 8'h00, 8'h00, 2'b01, 2'b01, 2'b11, 1'b1, 8'hA1, 1'b0};
    vecs[2]  = '{2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 2'b11, 1'b0, 8'hA1, 1'b0};
    vecs[3]  = '{2'b10, 8'h00, 8'h10, 2'b00, 2'b00, 2'b11, 1'b0, 8'hA1, 1'b0};
    vecs[4]  = '{2'b10, 8'h00, 8'h11, 2'b00, 2'b10, 2'b11, 1'b0, 8'hA1, 1'b0};
    vecs[5]  = '{2'b10, 8'h00, 8'h12, 2'b00, 2'b10, 2'b11, 1'b0, 8'hA1, 1'b0};
    vecs[6]  = '{2'b10, 8'h00, 8'h13, 2'b00, 2'b10, 2'b11, 1'b0, 8'hA1, 1'b0};
    vecs[7]  = '{2'b10, 8'h00, 8'h14, 2'b00, 2'b10, 2'b01, 1'b0, 8'hA1, 1'b0};
    vecs[8]  = '{2'b00, 8'h00, 8'h00, 2'b10, 2'b10, 2'b01, 1'b1, 8'h10, 1'b1};
    vecs[9]  = '{2'b00, 8'h00, 8'h00, 2'b10, 2'b10, 2'b11, 1'b1, 8'h11, 1'b1};
    vecs[10] = '{2'b00, 8'h00, 8'h00, 2'b10, 2'b10, 2'b11, 1'b1, 8'h12, 1'b1};
    vecs[11] = '{2'b00, 8'h00, 8'h00, 2'b10, 2'b10, 2'b11, 1'b1, 8'h13, 1'b1};
    vecs[12] = '{2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 2'b11, 1'b0, 8'h13, 1'b1};

    last_d   = 8'h00;
    last_s   = 1'b0;
    err_exp  = 1'b0;
    rst      = 1'b1;
    up_valid = 2'b00;
    up_data0 = '0;
    up_data1 = '0;
    grants   = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_requests", 32'(requests), 32'd0);
    chk("rst_up_ready", 32'(up_ready), 32'd3);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_src", 32'(out_src), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b0;

    // Single word latency, then fill/overflow/drain of channel 1.
    for (int i = 0; i < 13; i++) begin
      step(vecs[i].uv, vecs[i].d0, vecs[i].d1, vecs[i].g, rs, ys);
      chk($sformatf("vec%0d_req", i), 32'(rs), 32'(vecs[i].exp_req));
      chk($sformatf("vec%0d_rdy", i), 32'(ys), 32'(vecs[i].exp_rdy));
      chk($sformatf("vec%0d_ov", i), 32'(out_valid), 32'(vecs[i].exp_ov));
      chk($sformatf("vec%0d_od", i), 32'(out_data), 32'(vecs[i].exp_od));
      chk($sformatf("vec%0d_os", i), 32'(out_src), 32'(vecs[i].exp_os));
    end

    // Interleaved drain of two loaded channels.
    for (int k = 0; k < 3; k++) step(2'b11, 8'(8'h20 + k), 8'(8'h30 + k), 2'b00, rs, ys);
    for (int k = 0; k < 6; k++) begin
      step(2'b00, 8'h00, 8'h00, (k % 2 == 0) ? 2'b01 : 2'b10, rs, ys);
      chk("interleave_src", 32'(out_src), 32'(k % 2));
      chk("interleave_data", 32'(out_data),
          (k % 2 == 0) ? 32'(8'h20 + k / 2) : 32'(8'h30 + k / 2));
    end

    // Steady push+pop at count 2, long enough to wrap the pointers twice.
    step(2'b01, 8'h40, 8'h00, 2'b00, rs, ys);
    step(2'b01, 8'h41, 8'h00, 2'b00, rs, ys);
    for (int k = 0; k < 8; k++) begin
      step(2'b01, 8'(8'h42 + k), 8'h00, 2'b01, rs, ys);
      chk("wrap_oldest", 32'(out_data), 32'(8'h40 + k));
      chk("wrap_req", 32'(rs[0]), 32'd1);
    end
    step(2'b00, 8'h00, 8'h00, 2'b01, rs, ys);
    step(2'b00, 8'h00, 8'h00, 2'b01, rs, ys);
    chk("wrap_last", 32'(out_data), 32'h49);

    // Invalid grants: both bits, then a grant to an empty channel.
    step(2'b11, 8'h50, 8'h60, 2'b00, rs, ys);
    step(2'b00, 8'h00, 8'h00, 2'b11, rs, ys);
    chk("dual_grant_ov", 32'(out_valid), 32'd0);
    chk("dual_grant_err", 32'(err), 32'(ERR_EN));
    step(2'b00, 8'h00, 8'h00, 2'b01, rs, ys);
    step(2'b00, 8'h00, 8'h00, 2'b01, rs, ys);
    chk("empty_grant_ov", 32'(out_valid), 32'd0);
    step(2'b00, 8'h00, 8'h00, 2'b10, rs, ys);
    chk("after_invalid_data", 32'(out_data), 32'h60);
    chk("err_sticky", 32'(err), 32'(ERR_EN));

    // Asynchronous reset mid-drain with both channels at count 3.
    for (int k = 0; k < 3; k++) step(2'b11, 8'(8'h70 + k), 8'(8'h80 + k), 2'b00, rs, ys);
    step(2'b00, 8'h00, 8'h00, 2'b01, rs, ys);
    rst = 1'b1;
    #1;
    chk("arst_requests", 32'(requests), 32'd0);
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_up_ready", 32'(up_ready), 32'd3);
    chk("arst_err", 32'(err), 32'd0);
    mq0.delete();
    mq1.delete();
    sb.delete();
    err_exp = 1'b0;
    last_d  = 8'h00;
    last_s  = 1'b0;
    grants  = 2'b00;
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(2'b00, 8'h00, 8'h00, 2'b00, rs, ys);
    chk("no_replay_req", 32'(rs), 32'd0);
    step(2'b10, 8'h00, 8'h99, 2'b00, rs, ys);
    step(2'b00, 8'h00, 8'h00, 2'b10, rs, ys);
    chk("post_rst_data", 32'(out_data), 32'h99);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
